// File: rtl/alu_issue_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_pkg
// Shared definitions for the 4-bit ALU issue stage: instruction layout,
// op-code values, FSM state encoding and small decode helpers.
//
// Instruction word (INSTR_W = 15 bits):
//   [14]    use_imm
//   [13:10] op_code
//   [9:8]   rd
//   [7:6]   rs1
//   [5:4]   rs2
//   [3:0]   imm
// ---------------------------------------------------------------------------
package alu_issue_pkg;

   localparam int INSTR_W     = 15;
   localparam int DATA_W      = 4;
   localparam int REG_ADDR_W  = 2;
   localparam int NUM_REGS    = 4;

   localparam int USE_IMM_BIT = 14;
   localparam int OP_MSB      = 13;
   localparam int OP_LSB      = 10;
   localparam int RD_MSB      = 9;
   localparam int RD_LSB      = 8;
   localparam int RS1_MSB     = 7;
   localparam int RS1_LSB     = 6;
   localparam int RS2_MSB     = 5;
   localparam int RS2_LSB     = 4;
   localparam int IMM_MSB     = 3;
   localparam int IMM_LSB     = 0;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NAND = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1000;
   localparam logic [3:0] OP_XNOR = 4'b1001;
   localparam logic [3:0] OP_REM  = 4'b1010;

   // Plain constants are what the RTL compares against; the enum mirrors
   // them for anyone who wants a typed view of the state register.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EXEC = 1'b1;

   typedef enum logic [0:0] {
      STATE_IDLE = 1'b0,
      STATE_EXEC = 1'b1
   } state_e;

   // Only the arithmetic add/sub ops own the carry flag.
   function automatic logic op_writes_carry(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   function automatic logic op_is_divide(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Generic single-clock FIFO with show-ahead head output.
//
// Parameters:
//   DATA_W  entry width
//   DEPTH   number of entries (power of two, >= 2)
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset (empties the FIFO)
//   push, push_data write an entry; ignored when full
//   pop            retire the head entry; ignored when empty
//   head           current head entry (valid when !empty)
//   count          occupancy, 0..DEPTH
//   empty, full    occupancy flags decoded from count
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Storage carries no reset: only the pointers and count define contents.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issue stage for the external 4-bit ALU. Instructions are queued in a
// sync_fifo; a two-state FSM (IDLE/EXEC) pops one, latches its operands
// from a 4 x 4-bit register file (or the immediate) plus the carry flag,
// lets the ALU evaluate for one cycle and then writes the result back and
// pulses a writeback strobe. One instruction completes every two cycles.
//
// Parameters:
//   DEPTH  instruction FIFO depth (power of two, >= 2)
// Ports:
//   clk, rst_n           clock / asynchronous active-low reset
//   in_valid, in_ready   instruction handshake, in_instr is the word
//   alu_a, alu_b         registered ALU operands
//   alu_op, alu_cin      registered ALU op-code and carry-in
//   alu_result, alu_cout combinational ALU response
//   wb_valid             one-cycle completion strobe
//   wb_rd, wb_data       destination register and value written
//   wb_carry             carry flag after the instruction
//   wb_err               divide-by-zero trap flag (ALU_ISSUE_DIV0_TRAP_EN)
//   busy                 FSM in EXEC or FIFO non-empty
//   count                FIFO occupancy
//
// Build option ALU_ISSUE_DIV0_TRAP_EN: DIV/REM with a zero divisor leave
// the register file and carry untouched and complete with wb_err = 1,
// wb_data = 0. Without it the ALU result is written as-is.
// ---------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [14:0]                in_instr,
   output logic [3:0]                 alu_a,
   output logic [3:0]                 alu_b,
   output logic [3:0]                 alu_op,
   output logic                       alu_cin,
   input  logic [3:0]                 alu_result,
   input  logic                       alu_cout,
   output logic                       wb_valid,
   output logic [1:0]                 wb_rd,
   output logic [3:0]                 wb_data,
   output logic                       wb_carry,
`ifdef ALU_ISSUE_DIV0_TRAP_EN
   output logic                       wb_err,
`endif
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CNT_W = $clog2(DEPTH+1);

   logic [INSTR_W-1:0]    head;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  push;
   logic                  pop;

   logic [0:0]            state;
   logic                  exec;

   logic                  head_use_imm;
   logic [3:0]            head_op;
   logic [REG_ADDR_W-1:0] head_rd;
   logic [REG_ADDR_W-1:0] head_rs1;
   logic [REG_ADDR_W-1:0] head_rs2;
   logic [DATA_W-1:0]     head_imm;

   logic [DATA_W-1:0]     a_p1;
   logic [DATA_W-1:0]     b_p1;
   logic [3:0]            op_p1;
   logic                  cin_p1;
   logic [REG_ADDR_W-1:0] rd_p1;

   logic [DATA_W-1:0]     rf [NUM_REGS];
   logic                  carry_flag;
   logic                  carry_next;
   logic                  div0_trap;
   logic                  rf_wr_en;

   // in_ready looks only at the registered count, so a slot freed by a
   // same-cycle pop is not offered until the next cycle.
   assign in_ready = rst_n & ~fifo_full;
   assign push     = in_valid & in_ready;
   assign exec     = (state == ST_EXEC);
   assign pop      = (state == ST_IDLE) & ~fifo_empty;
   assign busy     = exec | ~fifo_empty;

   sync_fifo #(
      .DATA_W (INSTR_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (in_instr),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign head_use_imm = head[USE_IMM_BIT];
   assign head_op      = head[OP_MSB:OP_LSB];
   assign head_rd      = head[RD_MSB:RD_LSB];
   assign head_rs1     = head[RS1_MSB:RS1_LSB];
   assign head_rs2     = head[RS2_MSB:RS2_LSB];
   assign head_imm     = head[IMM_MSB:IMM_LSB];

   // ---- stage p1: pop head, register operands (IDLE edge) ----
   // The operand registers hold steady through EXEC so the combinational
   // ALU sees a stable input for the whole cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         a_p1   <= '0;
         b_p1   <= '0;
         op_p1  <= '0;
         cin_p1 <= 1'b0;
         rd_p1  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  a_p1   <= rf[head_rs1];
                  b_p1   <= head_use_imm ? head_imm : rf[head_rs2];
                  op_p1  <= head_op;
                  cin_p1 <= carry_flag;
                  rd_p1  <= head_rd;
                  state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign alu_a   = a_p1;
   assign alu_b   = b_p1;
   assign alu_op  = op_p1;
   assign alu_cin = cin_p1;

`ifdef ALU_ISSUE_DIV0_TRAP_EN
   assign div0_trap = exec & op_is_divide(op_p1) & (b_p1 == '0);
`else
   assign div0_trap = 1'b0;
`endif

   assign rf_wr_en = exec & ~div0_trap;

   always_comb begin
      carry_next = carry_flag;
      if (rf_wr_en && op_writes_carry(op_p1)) begin
         carry_next = alu_cout;
      end
   end

   // ---- stage p2: commit ALU result to rf/carry (EXEC edge) ----
   // No hazard logic: rf is written here and read no earlier than the
   // following IDLE edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf[i] <= '0;
         end
         carry_flag <= 1'b0;
      end else begin
         if (rf_wr_en) begin
            rf[rd_p1] <= alu_result;
         end
         carry_flag <= carry_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         wb_carry <= 1'b0;
`ifdef ALU_ISSUE_DIV0_TRAP_EN
         wb_err   <= 1'b0;
`endif
      end else begin
         wb_valid <= exec;
         if (exec) begin
            wb_rd    <= rd_p1;
            wb_data  <= div0_trap ? '0 : alu_result;
            wb_carry <= carry_next;
`ifdef ALU_ISSUE_DIV0_TRAP_EN
            wb_err   <= div0_trap;
`endif
         end
      end
   end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Upstream issue stage for the 4-bit `alu`. It buffers packed instructions in a small FIFO and reads operands from a 4-entry × 4-bit register file plus a carry flag. It drives the ALU's `a`/`b`/`op_code`/`carry_in`, captures `result`/`carry_out` back into the register file, and reports each completion on a one-cycle writeback strobe.

## Interface
- `DEPTH`, default 4: instruction FIFO depth; power of two, ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: instruction offered.
- `in_ready`  out  1: FIFO can accept an instruction.
- `in_instr`  in  15: instruction word, with these fields:
  - `[14]` use_imm
  - `[13:10]` op_code
  - `[9:8]` rd
  - `[7:6]` rs1
  - `[5:4]` rs2
  - `[3:0]` imm
- `alu_a`, `alu_b`  out  4 each: ALU operands.
- `alu_op`  out  4: ALU op_code.
- `alu_cin`  out  1: ALU carry_in.
- `alu_result`  in  4: ALU result (combinational from the `alu_*` outputs).
- `alu_cout`  in  1: ALU carry_out.
- `wb_valid`  out  1: one-cycle completion strobe.
- `wb_rd`  out  2: destination register of the completed instruction.
- `wb_data`  out  4: value written to `rd`.
- `wb_carry`  out  1: carry flag after the instruction.
- `busy`  out  1: FSM in EXEC, or FIFO not empty.
- `count`  out  $clog2(DEPTH+1): FIFO occupancy.

## Operation
- **Handshake**
  - Push occurs on an edge where `in_valid && in_ready`.
  - `in_ready = (count != DEPTH)`, computed from registered count only; a pop in the same cycle does not free a slot.
  - `in_instr` may change freely while `in_ready` is low.
- **FSM states:** IDLE, EXEC.
- **IDLE**
  - If the FIFO is non-empty, pop the head and register the operands, then go to EXEC; otherwise stay.
  - `alu_a` = rf[rs1].
  - `alu_b` = imm if use_imm, else rf[rs2].
  - `alu_op` = op_code; `alu_cin` = carry flag.
- **EXEC**
  - Operand registers are held stable for the ALU.
  - At the edge:
    - Write rf[rd] ← `alu_result`.
    - Update the carry flag ← `alu_cout` only for op_code 0000 (add) or 0001 (sub); otherwise hold it.
    - Load `wb_rd`, `wb_data`, `wb_carry`; set `wb_valid` = 1.
  - Always return to IDLE.
- **Hazards:** none possible. rf is written at the EXEC edge and read no earlier than the following IDLE edge.
- **Op codes:** all 16 are issued unchanged. Codes 1011 and 11xx yield ALU result 0, which is written to rd.
- **No backpressure on writeback:** `wb_valid` is a pure strobe.
- **Reset (asynchronous, any state including mid-EXEC):**
  - State → IDLE; FIFO emptied and `count` = 0.
  - rf all 0; carry flag 0.
  - `alu_a`/`alu_b`/`alu_op`/`alu_cin` = 0.
  - `wb_*` = 0, `busy` = 0, `in_ready` = 0 while `rst_n` is low.
  - An in-flight instruction is discarded without writeback.

## Timing
- **Accept-to-writeback latency, FSM idle:**
  - Pushed at edge E0 → popped at E1 → written at E2.
  - `wb_valid` is high in the cycle after E2.
- **Throughput:** one instruction per 2 cycles.
- **Overflow:** a sustained push every cycle fills the FIFO; `in_ready` then toggles as slots free.
- **Ordering:** `count` wraps never. Pointers wrap modulo DEPTH. Completion order equals push order.

## Configuration
- **`ALU_ISSUE_DIV0_TRAP_EN` defined:**
  - Adds output `wb_err` (1 bit, reset 0).
  - For op_code 0011 (div) or 1010 (rem) with `alu_b` == 0, the EXEC edge leaves rf[rd] and the carry flag unchanged.
  - It pulses `wb_valid` with `wb_err` = 1 and `wb_data` = 0.
  - `wb_err` = 0 for all other completions.
- **Undefined:** no `wb_err` port; divide-by-zero writes whatever `alu_result` presents.

## Structure
- **Package `alu_issue_pkg`:**
  - Op-code constants: ADD, SUB, MUL, DIV, AND, OR, XOR, NAND, NOR, XNOR, REM.
  - Instruction field bit positions.
  - FSM state enum.
  - Instruction width (15).
- **Sub-module `sync_fifo`:** parameterised width/depth; provides push, pop, head, count. It is reusable elsewhere.
- The register file, carry flag and FSM stay in `alu_issue_ctrl`. The `alu` is instantiated by the parent, not inside this block.

## Test plan
- **Load immediate:** reset, then push {use_imm=1, ADD, rd=1, rs1=0, imm=5} → `wb_valid` one cycle after E2 with `wb_rd`=1, `wb_data`=5, `wb_carry`=0.
- **Carry chain:**
  - Load r1=0xF, then ADD r2=r1+imm 1 → `wb_data`=0, `wb_carry`=1.
  - Then ADD r3=r0+imm 0 → `wb_data`=1 (cin used), `wb_carry`=0.
- **Logic op:** r1=0xA, then XOR r2=r1,imm 0x6 → `wb_data`=0xC; carry flag unchanged from its prior value.
- **FIFO full (DEPTH=4):**
  - Hold `in_valid` high with 8 distinct loads.
  - `count` reaches 4 and `in_ready` deasserts.
  - No instruction is lost or duplicated; 8 writebacks arrive in push order.
- **Div-by-zero with `ALU_ISSUE_DIV0_TRAP_EN`:** r1=7, then DIV r1=r1/imm 0 → `wb_err`=1, `wb_data`=0, r1 remains 7 (checked by a following OR r2=r1,imm 0 → 7).
- **Reset mid-EXEC:**
  - Assert `rst_n` low during EXEC of ADD r1=r0+imm 9.
  - No `wb_valid`, `count`=0, all outputs 0.
  - After release, OR r2=r1,imm 0 returns 0.
